// File: rtl/oric_printer_port.sv
// Oric printer port responder: catches Centronics strobes from the VIA,
// queues each byte in a FIFO for the host stream, and answers with a
// timed active-low acknowledge. Acknowledges are withheld while full.
module oric_printer_port #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ACK_DELAY = 2,
    parameter int unsigned ACK_WIDTH = 5
) (
    input  logic                      CLK_IN,
    input  logic                      RESETn,
    input  logic                      ENA_1MHZ,
    input  logic                      PRN_STROBE,
    input  logic [7:0]                PRN_DATA,
    output logic                      PRN_ACK_L,
    output logic                      PRN_BUSY,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    input  logic                      overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DELAY = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    // Where an accepted byte's acknowledge sequence begins: a zero delay
    // skips DELAY and drops ACK_L on the very next edge.
    localparam logic [1:0]    START_STATE = (ACK_DELAY == 0) ? S_ACK : S_DELAY;
    localparam logic [CW-1:0] START_CNT   = (ACK_DELAY == 0) ? CW'(ACK_WIDTH) : CW'(ACK_DELAY);

    logic          stb_q;
    logic          armed_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic [7:0]    hold_q, hold_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    mem [DEPTH];

    logic          capture;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic [7:0]    push_byte;
    logic          ovf_set;

    // Falling-edge capture; armed_q blocks a strobe that was already low at reset release.
    assign capture = armed_q & stb_q & ~PRN_STROBE;

    // Full/empty are judged on the pre-pop level so a push at full never sneaks in.
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign pop   = ~empty & out_ready;

    assign out_valid  = ~empty;
    assign out_data   = empty ? 8'h00 : mem[rd_ptr_q];
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign PRN_ACK_L  = (state_q != S_ACK);
    assign PRN_BUSY   = (state_q == S_HOLD);

    // Handshake FSM: decides pushes, holding, drops and acknowledge timing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        hold_d    = hold_q;
        ovf_set   = 1'b0;
        push      = 1'b0;
        push_byte = PRN_DATA;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    if (!full) begin
                        push    = 1'b1;
                        state_d = START_STATE;
                        cnt_d   = START_CNT;
                    end else begin
                        hold_d  = PRN_DATA;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                push_byte = hold_q;
                if (capture) begin
                    ovf_set = 1'b1;
                end
                if (!full) begin
                    push    = 1'b1;
                    state_d = START_STATE;
                    cnt_d   = START_CNT;
                end
            end
            S_DELAY: begin
                if (capture) begin
                    if (!full) begin
                        push = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                pending_d = pending_q | capture;
                if (ENA_1MHZ) begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = S_ACK;
                        cnt_d   = CW'(ACK_WIDTH);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: begin
                if (capture) begin
                    if (!full) begin
                        push = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                pending_d = pending_q | capture;
                if (ENA_1MHZ) begin
                    if (cnt_q <= CW'(1)) begin
                        // A capture landing on the final tick still earns its pulse.
                        if (pending_q || capture) begin
                            pending_d = 1'b0;
                            state_d   = START_STATE;
                            cnt_d     = START_CNT;
                        end else begin
                            pending_d = 1'b0;
                            state_d   = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
        endcase
    end

    // Level bookkeeping; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Sticky overflow; a new drop in the same cycle outranks the clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (overflow_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State, pointer and control registers.
    always_ff @(posedge CLK_IN) begin
        if (!RESETn) begin
            stb_q     <= 1'b1;
            armed_q   <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            hold_q    <= 8'h00;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            stb_q     <= PRN_STROBE;
            armed_q   <= 1'b1;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
            ovf_q     <= ovf_d;
            level_q   <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since the level gates visibility.
    always_ff @(posedge CLK_IN) begin
        if (RESETn && push) begin
            mem[wr_ptr_q] <= push_byte;
        end
    end

endmodule
